// File: rtl/fft4_sample_packer.sv
// Serial-to-parallel framer for the 4-point FFT core: groups four samples
// into one a/b/c/d frame behind a registered valid/ready output slot.
module fft4_sample_packer #(
    parameter int W     = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_sof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_a,
    output logic [W-1:0]     out_b,
    output logic [W-1:0]     out_c,
    output logic [W-1:0]     out_d,
    output logic [ERR_W-1:0] err_cnt
);

    logic [1:0]       cnt_q, cnt_d;
    logic [W-1:0]     s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic             ov_q, ov_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             accept;

    // Only a completing beat into an occupied, non-draining slot must wait.
    assign in_ready = !rst && !(cnt_q == 2'd3 && ov_q && !out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        cnt_d = cnt_q;
        s0_d  = s0_q;
        s1_d  = s1_q;
        s2_d  = s2_q;
        a_d   = a_q;
        b_d   = b_q;
        c_d   = c_q;
        d_d   = d_q;
        ov_d  = ov_q && !out_ready;
        err_d = err_q;
        if (accept) begin
            if (in_sof) begin
                if (cnt_q != 2'd0 && err_q != '1)
                    err_d = err_q + 1'b1;
                s0_d  = in_data;
                cnt_d = 2'd1;
            end else if (cnt_q == 2'd3) begin
                a_d   = s0_q;
                b_d   = s1_q;
                c_d   = s2_q;
                d_d   = in_data;
                ov_d  = 1'b1;
                cnt_d = 2'd0;
            end else begin
                unique case (cnt_q)
                    2'd0:    s0_d = in_data;
                    2'd1:    s1_d = in_data;
                    default: s2_d = in_data;
                endcase
                cnt_d = cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            s0_q  <= '0;
            s1_q  <= '0;
            s2_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            d_q   <= '0;
            ov_q  <= 1'b0;
            err_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            s0_q  <= s0_d;
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            a_q   <= a_d;
            b_q   <= b_d;
            c_q   <= c_d;
            d_q   <= d_d;
            ov_q  <= ov_d;
            err_q <= err_d;
        end
    end

    assign out_valid = ov_q;
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign out_c     = c_q;
    assign out_d     = d_q;
    assign err_cnt   = err_q;

endmodule
